regfile_wb_arbiter: RTL and testbench

//  Round-robin arbiter sharing the register file's single write port among
//  NUM_REQ write-back sources (e.g. ALU, load unit, multiplier).

---
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the requesters and the register-file write-port arbiter.
// Requester side is the master; the arbiter is the slave.
interface regfile_wb_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      reg_write;
  logic [ADDR_W-1:0]         write_reg;
  logic [DATA_W-1:0]         write_data;
  logic [2:0]                grant_id;
  logic                      fwd_valid;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, reg_write, write_reg, write_data, grant_id, fwd_valid
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, reg_write, write_reg, write_data, grant_id, fwd_valid
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// one-entry registered output stage (also the forwarding source) and a saturating contention counter.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_enable,
  regfile_wb_if.slave      bus,
  output logic [CNT_W-1:0] contention
);
  localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

  logic [2:0]         r_ptr;
  logic               r_vld_p1;
  logic [ADDR_W-1:0]  r_write_reg_p1;
  logic [DATA_W-1:0]  r_write_data_p1;
  logic [2:0]         r_grant_id_p1;
  logic [CNT_W-1:0]   r_contention;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_any;
  logic [2:0]         w_gnt_idx;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;
  logic               w_contend;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: arbitration. Scan ptr..NUM_REQ-1 first, then 0..ptr-1 to wrap.
  always_comb begin
    w_grant   = '0;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_addr    = '0;
    w_data    = '0;
    if (!reset && wb_enable) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && bus.req_valid[i] && (i >= int'(r_ptr))) begin
          w_any      = 1'b1;
          w_grant[i] = 1'b1;
          w_gnt_idx  = 3'(i);
          w_addr     = bus.req_addr[i*ADDR_W +: ADDR_W];
          w_data     = bus.req_data[i*DATA_W +: DATA_W];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_any && bus.req_valid[i] && (i < int'(r_ptr))) begin
          w_any      = 1'b1;
          w_grant[i] = 1'b1;
          w_gnt_idx  = 3'(i);
          w_addr     = bus.req_addr[i*ADDR_W +: ADDR_W];
          w_data     = bus.req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign w_contend = wb_enable && ($countones(bus.req_valid) >= 2);

  // Stage p1: output register; writes to register 0 are accepted but never enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr           <= '0;
      r_vld_p1        <= 1'b0;
      r_write_reg_p1  <= '0;
      r_write_data_p1 <= '0;
      r_grant_id_p1   <= '0;
      r_contention    <= '0;
    end else begin
      if (w_any) begin
        r_ptr           <= (w_gnt_idx == LAST_IDX) ? 3'd0 : w_gnt_idx + 3'd1;
        r_vld_p1        <= (w_addr != '0);
        r_write_reg_p1  <= w_addr;
        r_write_data_p1 <= w_data;
        r_grant_id_p1   <= w_gnt_idx;
      end else begin
        r_vld_p1        <= 1'b0;
      end
      if (w_contend) begin
        r_contention <= sat_inc(r_contention);
      end
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.reg_write  = r_vld_p1;
  assign bus.fwd_valid  = r_vld_p1;
  assign bus.write_reg  = r_write_reg_p1;
  assign bus.write_data = r_write_data_p1;
  assign bus.grant_id   = r_grant_id_p1;
  assign contention     = r_contention;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        reset;
  logic        wb_enable;
  logic [15:0] contention;
  int          n_assert;
  int          n_fail;
  int          gcnt [3];

  regfile_wb_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_enable  (wb_enable),
    .bus        (bus),
    .contention (contention)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    bus.req_valid = v;
    bus.req_addr  = {a2, a1, a0};
    bus.req_data  = {d2, d1, d0};
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic rw, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [2:0] gid);
    chk({tag, "_reg_write"}, 32'(bus.reg_write), 32'(rw));
    chk({tag, "_fwd_valid"}, 32'(bus.fwd_valid), 32'(rw));
    chk({tag, "_write_reg"}, 32'(bus.write_reg), 32'(wr));
    chk({tag, "_write_data"}, bus.write_data, wd);
    chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'(gid));
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    wb_enable = 1'b1;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk_wr("rst", 1'b0, 5'd0, 32'd0, 3'd0);
    chk("rst_contention", 32'(contention), 32'd0);

    // Test 1: three requests, each drops after acceptance
    reset = 1'b0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
    chk("t1_ready0", 32'(bus.req_ready), 32'b001);
    tick();
    chk_wr("t1_w1", 1'b1, 5'd1, 32'hA, 3'd0);
    drive(3'b110, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
    chk("t1_ready1", 32'(bus.req_ready), 32'b010);
    tick();
    chk_wr("t1_w2", 1'b1, 5'd2, 32'hB, 3'd1);
    drive(3'b100, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC);
    chk("t1_ready2", 32'(bus.req_ready), 32'b100);
    tick();
    chk_wr("t1_w3", 1'b1, 5'd3, 32'hC, 3'd2);
    chk("t1_contention", 32'(contention), 32'd2);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk_wr("t1_idle", 1'b0, 5'd3, 32'hC, 3'd2);

    // Test 2: write to register 0 is accepted but not enabled; pointer wraps
    drive(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEAD, 32'h0);
    chk("t2_ready_r0", 32'(bus.req_ready), 32'b010);
    tick();
    chk_wr("t2_r0", 1'b0, 5'd0, 32'hDEAD, 3'd1);
    drive(3'b011, 5'd4, 5'd9, 5'd0, 32'h44, 32'h99, 32'h0);
    chk("t2_ready_wrap", 32'(bus.req_ready), 32'b001);
    tick();
    chk_wr("t2_wrap", 1'b1, 5'd4, 32'h44, 3'd0);
    chk("t2_contention", 32'(contention), 32'd3);
    drive(3'b100, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h66);
    chk("t2_ready_r2", 32'(bus.req_ready), 32'b100);
    tick();
    chk_wr("t2_r2", 1'b1, 5'd6, 32'h66, 3'd2);

    // Test 3: all three held valid for nine cycles
    drive(3'b111, 5'd11, 5'd12, 5'd13, 32'h110, 32'h120, 32'h130);
    for (int k = 0; k < 9; k++) begin
      chk("t3_ready", 32'(bus.req_ready), 32'(3'b001 << (k % 3)));
      for (int r = 0; r < 3; r++) if (bus.req_ready[r]) gcnt[r]++;
      tick();
      chk("t3_grant_id", 32'(bus.grant_id), 32'(k % 3));
      chk("t3_reg_write", 32'(bus.reg_write), 32'd1);
    end
    for (int r = 0; r < 3; r++) chk("t3_grant_count", 32'(gcnt[r]), 32'd3);
    chk("t3_contention", 32'(contention), 32'd12);

    // Test 4: disable mid-stream; the last captured write still appears
    wb_enable = 1'b0;
    drive(3'b101, 5'd14, 5'd0, 5'd15, 32'h140, 32'h0, 32'h150);
    chk("t4_ready_off", 32'(bus.req_ready), 32'd0);
    chk_wr("t4_drain", 1'b1, 5'd13, 32'h130, 3'd2);
    tick();
    chk("t4_no_write", 32'(bus.reg_write), 32'd0);
    chk("t4_contention_hold", 32'(contention), 32'd12);
    tick();
    chk("t4_contention_hold2", 32'(contention), 32'd12);
    wb_enable = 1'b1;
    #1;
    chk("t4_ready_on", 32'(bus.req_ready), 32'b001);
    tick();
    chk_wr("t4_resume", 1'b1, 5'd14, 32'h140, 3'd0);
    chk("t4_contention", 32'(contention), 32'd13);

    // Test 5: reset while a write to register 7 sits in the output stage
    drive(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h77, 32'h0);
    chk("t5_ready", 32'(bus.req_ready), 32'b010);
    tick();
    chk_wr("t5_stage", 1'b1, 5'd7, 32'h77, 3'd1);
    reset = 1'b1;
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    chk_wr("t5_after_rst", 1'b0, 5'd0, 32'd0, 3'd0);
    chk("t5_contention", 32'(contention), 32'd0);
    reset = 1'b0;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    chk("t5_ptr_zero", 32'(bus.req_ready), 32'b001);
    tick();
    chk_wr("t5_first", 1'b1, 5'd1, 32'h1, 3'd0);

    // Test 6: contention saturates at all-ones
    repeat (65533) tick();
    chk("t6_fffe", 32'(contention), 32'hFFFE);
    tick();
    chk("t6_ffff", 32'(contention), 32'hFFFF);
    tick();
    tick();
    chk("t6_saturated", 32'(contention), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
